// File: rtl/burst_ram_pkg.sv
// Shared opcode constants and output-FSM state type for the burst_ram command RAM.
package burst_ram_pkg;

  typedef logic [1:0] opcode_t;

  localparam opcode_t OP_WR_ADDR = 2'b00;
  localparam opcode_t OP_WR_DATA = 2'b01;
  localparam opcode_t OP_RD_ADDR = 2'b10;
  localparam opcode_t OP_RD_DATA = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/burst_ram_if.sv
// Command-in / read-data-out bundle between a command source and burst_ram.
interface burst_ram_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W+1:0] din;
  logic              rx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              rd_ovf;

  modport master (
    output din, rx_valid, tx_ready,
    input  dout, tx_valid, rd_ovf
  );

  modport slave (
    input  din, rx_valid, tx_ready,
    output dout, tx_valid, rd_ovf
  );

endinterface

// File: rtl/burst_ram_mem.sv
// Single-port DEPTH x DATA_W RAM with synchronous write and registered read.
// Out-of-range writes are dropped and out-of-range reads return zero.
module burst_ram_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic              in_range;

  assign in_range = (32'(addr) < DEPTH);
  assign rdata    = rdata_q;

  // Array has no reset so it maps onto block RAM; only the output register clears.
  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem_q[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= in_range ? mem_q[addr] : '0;
    end
  end

endmodule

// File: rtl/burst_ram.sv
// Command-driven RAM: opcode decode, independent write/read address registers and a
// two-state output holding FSM. Define BURST_RAM_AUTOINC_EN for post-access address increment.
module burst_ram
  import burst_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic           clk,
  input  logic           rst_n,
  burst_ram_if.slave     bus
);

  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  state_t            state_q, state_d;
  logic              rd_ovf_q, rd_ovf_d;

  opcode_t           op;
  logic [ADDR_W-1:0] pay_addr;
  logic              cmd_wr, cmd_rd, rd_accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  assign op       = bus.din[DATA_W+1:DATA_W];
  assign pay_addr = bus.din[ADDR_W-1:0];

  always_comb begin
    cmd_wr    = bus.rx_valid && (op == OP_WR_DATA);
    cmd_rd    = bus.rx_valid && (op == OP_RD_DATA);
    // A read is only lost when the previous result is still waiting for the consumer.
    rd_accept = cmd_rd && ((state_q == ST_IDLE) || bus.tx_ready);
    rd_ovf_d  = cmd_rd && !rd_accept;
  end

`ifdef BURST_RAM_AUTOINC_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  function automatic logic [ADDR_W-1:0] inc_wrap(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction
`endif

  always_comb begin
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    if (bus.rx_valid && (op == OP_WR_ADDR)) wr_addr_d = pay_addr;
    if (bus.rx_valid && (op == OP_RD_ADDR)) rd_addr_d = pay_addr;
`ifdef BURST_RAM_AUTOINC_EN
    if (cmd_wr)    wr_addr_d = inc_wrap(wr_addr_q);
    if (rd_accept) rd_addr_d = inc_wrap(rd_addr_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      rd_ovf_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      rd_ovf_q  <= rd_ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (rd_accept) state_d = ST_HOLD;
      ST_HOLD: if (bus.tx_ready && !rd_accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.tx_valid = (state_q == ST_HOLD);
    bus.rd_ovf   = rd_ovf_q;
    bus.dout     = mem_rdata;
  end

  // Commands are one per cycle, so the single RAM port is never contended.
  assign mem_we   = cmd_wr && rst_n;
  assign mem_addr = rd_accept ? rd_addr_q : wr_addr_q;

  burst_ram_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .re    (rd_accept),
    .addr  (mem_addr),
    .wdata (bus.din[DATA_W-1:0]),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_burst_ram.sv
// Self-checking bench for burst_ram: vector table plus hand sequences, dout via scoreboard.
module tb_burst_ram;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  burst_ram_if #(.DATA_W(8)) a_if ();
  burst_ram_if #(.DATA_W(8)) b_if ();

  burst_ram #(.DATA_W(8), .ADDR_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  burst_ram #(.DATA_W(8), .ADDR_W(8), .DEPTH(200)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  typedef struct {
    bit       rv;
    bit [1:0] op;
    bit [7:0] pay;
    bit       rdy;
    bit       etv;
    bit       eovf;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model for dut_a
  logic [7:0] sh_mem [256];
  bit         sh_known [256];
  bit   [7:0] m_wr, m_rd;
  bit         hold;
  logic [7:0] exp_dout;
  bit         dout_known;
  logic [8:0] sb [$];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic step(input bit rv, input bit [1:0] op, input bit [7:0] pay, input bit rdy,
                      input bit etv, input bit eovf, input string nm);
    bit acc;
    logic [8:0] e;
    a_if.din      = {op, pay};
    a_if.rx_valid = rv;
    a_if.tx_ready = rdy;
    acc = rv && (op == 2'b11) && (!hold || rdy);
    if (acc) begin
      sb.push_back({sh_known[m_rd], sh_mem[m_rd]});
`ifdef BURST_RAM_AUTOINC_EN
      m_rd++;
`endif
    end
    if (rv && op == 2'b00) m_wr = pay;
    if (rv && op == 2'b10) m_rd = pay;
    if (rv && op == 2'b01) begin
      sh_mem[m_wr]   = pay;
      sh_known[m_wr] = 1'b1;
`ifdef BURST_RAM_AUTOINC_EN
      m_wr++;
`endif
    end
    @(posedge clk);
    #1;
    $display("step %s op=%0d pay=%02h rdy=%0d -> tv=%0d ovf=%0d dout=%02h",
             nm, op, pay, rdy, a_if.tx_valid, a_if.rd_ovf, a_if.dout);
    check({nm, " tx_valid"}, a_if.tx_valid, etv);
    check({nm, " rd_ovf"}, a_if.rd_ovf, eovf);
    if (acc) begin
      e          = sb.pop_front();
      dout_known = e[8];
      exp_dout   = e[7:0];
    end
    if (dout_known) check({nm, " dout"}, a_if.dout, exp_dout);
    hold = etv;
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    a_if.din = {2'b11, 8'h00}; a_if.rx_valid = 1'b1; a_if.tx_ready = 1'b0;
    b_if.din = {2'b01, 8'hEE}; b_if.rx_valid = 1'b1; b_if.tx_ready = 1'b0;
    @(posedge clk);
    #1;
    $display("reset %s -> tv=%0d dout=%02h ovf=%0d", nm, a_if.tx_valid, a_if.dout, a_if.rd_ovf);
    check({nm, " a tx_valid"}, a_if.tx_valid, 0);
    check({nm, " a dout"}, a_if.dout, 0);
    check({nm, " a rd_ovf"}, a_if.rd_ovf, 0);
    check({nm, " b tx_valid"}, b_if.tx_valid, 0);
    check({nm, " b dout"}, b_if.dout, 0);
    rst_n = 1'b1;
    a_if.rx_valid = 1'b0;
    b_if.rx_valid = 1'b0;
    hold = 1'b0; m_wr = '0; m_rd = '0;
    exp_dout = '0; dout_known = 1'b1;
    sb.delete();
  endtask

  task automatic b_step(input bit rv, input bit [1:0] op, input bit [7:0] pay, input bit rdy);
    b_if.din = {op, pay}; b_if.rx_valid = rv; b_if.tx_ready = rdy;
    @(posedge clk);
    #1;
    $display("b_step op=%0d pay=%02h -> tv=%0d dout=%02h", op, pay, b_if.tx_valid, b_if.dout);
  endtask

  vec_t vecs [25];

  initial begin
    vecs[0]  = '{1, 2'b00, 8'h10, 1, 0, 0};
    vecs[1]  = '{1, 2'b01, 8'hA5, 1, 0, 0};
    vecs[2]  = '{1, 2'b10, 8'h10, 1, 0, 0};
    vecs[3]  = '{1, 2'b11, 8'h00, 1, 1, 0};  // read from IDLE: 0xA5 next edge
    vecs[4]  = '{0, 2'b00, 8'h00, 1, 0, 0};  // consumed, back to IDLE
    vecs[5]  = '{1, 2'b00, 8'h20, 0, 0, 0};
    vecs[6]  = '{1, 2'b01, 8'h3C, 0, 0, 0};
    vecs[7]  = '{1, 2'b10, 8'h10, 0, 0, 0};
    vecs[8]  = '{1, 2'b11, 8'h00, 0, 1, 0};
    vecs[9]  = '{0, 2'b00, 8'h00, 0, 1, 0};
    vecs[10] = '{1, 2'b11, 8'h00, 0, 1, 1};  // dropped read while stalled
    vecs[11] = '{0, 2'b00, 8'h00, 0, 1, 0};
    vecs[12] = '{0, 2'b00, 8'h00, 0, 1, 0};
    vecs[13] = '{0, 2'b00, 8'h00, 0, 1, 0};
    vecs[14] = '{1, 2'b10, 8'h20, 0, 1, 0};  // address load while holding
    vecs[15] = '{1, 2'b11, 8'h00, 1, 1, 0};  // consume + read same cycle: 0x3C
    vecs[16] = '{0, 2'b00, 8'h00, 1, 0, 0};
    vecs[17] = '{1, 2'b00, 8'h30, 1, 0, 0};  // wr_addr load leaves rd_addr alone
    vecs[18] = '{1, 2'b11, 8'h00, 1, 1, 0};
    vecs[19] = '{0, 2'b00, 8'h00, 1, 0, 0};
    vecs[20] = '{1, 2'b10, 8'h41, 1, 0, 0};
    vecs[21] = '{1, 2'b00, 8'h41, 1, 0, 0};
    vecs[22] = '{1, 2'b01, 8'h5A, 1, 0, 0};
    vecs[23] = '{1, 2'b11, 8'h00, 1, 1, 0};  // read right after write
    vecs[24] = '{0, 2'b00, 8'h00, 1, 0, 0};

    a_if.din = '0; a_if.rx_valid = 1'b0; a_if.tx_ready = 1'b0;
    b_if.din = '0; b_if.rx_valid = 1'b0; b_if.tx_ready = 1'b0;
    for (int i = 0; i < 256; i++) sh_known[i] = 1'b0;
    @(posedge clk);
    do_reset("init");

    for (int i = 0; i < 25; i++) begin
      step(vecs[i].rv, vecs[i].op, vecs[i].pay, vecs[i].rdy, vecs[i].etv, vecs[i].eovf,
           $sformatf("vec%0d", i));
    end

    // Reset in the middle of HOLD; memory must survive
    step(1, 2'b00, 8'h00, 1, 0, 0, "rs_wa");
    step(1, 2'b01, 8'hC3, 1, 0, 0, "rs_wd");
    step(1, 2'b10, 8'h41, 1, 0, 0, "rs_ra");
    step(1, 2'b11, 8'h00, 0, 1, 0, "rs_rd");
    do_reset("hold_reset");
    step(1, 2'b11, 8'h00, 1, 1, 0, "rs_after_rd");
    step(1, 2'b01, 8'h7E, 1, 0, 0, "rs_wr0");
    step(1, 2'b10, 8'h00, 1, 0, 0, "rs_ra0");
    step(1, 2'b11, 8'h00, 1, 1, 0, "rs_rd0");
    step(0, 2'b00, 8'h00, 1, 0, 0, "rs_idle");

`ifdef BURST_RAM_AUTOINC_EN
    step(1, 2'b00, 8'hFE, 1, 0, 0, "ai_wa");
    step(1, 2'b01, 8'h11, 1, 0, 0, "ai_w0");
    step(1, 2'b01, 8'h22, 1, 0, 0, "ai_w1");
    step(1, 2'b01, 8'h33, 1, 0, 0, "ai_w2");
    step(1, 2'b10, 8'hFE, 1, 0, 0, "ai_ra");
    step(1, 2'b11, 8'h00, 1, 1, 0, "ai_r0");
    step(1, 2'b11, 8'h00, 1, 1, 0, "ai_r1");
    step(1, 2'b11, 8'h00, 1, 1, 0, "ai_r2");
    step(0, 2'b00, 8'h00, 1, 0, 0, "ai_idle");
    check("ai wrap data", a_if.dout, 8'h33);
`else
    step(1, 2'b00, 8'h50, 1, 0, 0, "ni_wa");
    step(1, 2'b01, 8'h11, 1, 0, 0, "ni_w0");
    step(1, 2'b01, 8'h22, 1, 0, 0, "ni_w1");
    step(1, 2'b10, 8'h50, 1, 0, 0, "ni_ra");
    step(1, 2'b11, 8'h00, 1, 1, 0, "ni_r0");
    step(1, 2'b11, 8'h00, 1, 1, 0, "ni_r1");
    step(0, 2'b00, 8'h00, 1, 0, 0, "ni_idle");
    check("ni overwrite data", a_if.dout, 8'h22);
`endif

    // DEPTH=200 instance: out-of-range write ignored, read returns zero
    b_step(1, 2'b00, 8'hC7, 1);
    b_step(1, 2'b01, 8'h66, 1);
    b_step(1, 2'b00, 8'hF0, 1);
    b_step(1, 2'b01, 8'h77, 1);
    b_step(1, 2'b10, 8'hC7, 1);
    b_step(1, 2'b11, 8'h00, 1);
    check("b last word tx_valid", b_if.tx_valid, 1);
    check("b last word dout", b_if.dout, 8'h66);
    b_step(1, 2'b10, 8'hF0, 1);
    check("b tx_valid drop", b_if.tx_valid, 0);
    b_step(1, 2'b11, 8'h00, 1);
    check("b oor tx_valid", b_if.tx_valid, 1);
    check("b oor dout", b_if.dout, 8'h00);
    b_step(1, 2'b10, 8'hC7, 1);
    b_step(1, 2'b11, 8'h00, 1);
    check("b last word intact", b_if.dout, 8'h66);
    b_step(0, 2'b00, 8'h00, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/burst_ram.md
BURST_RAM -- requirements
Module: burst_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 8, memory word and address-payload width.
REQ-002 SHALL have parameter ADDR_W, default 8, address width; ADDR_W <= DATA_W.
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_W, number of words; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port din  input  DATA_W+2  command: din[DATA_W+1:DATA_W] opcode, din[DATA_W-1:0] payload.
REQ-007 SHALL have port rx_valid  input  1  din is a valid command this cycle.
REQ-008 SHALL have port tx_ready  input  1  consumer accepts dout this cycle.
REQ-009 SHALL have port dout  output  DATA_W  read data, registered.
REQ-010 SHALL have port tx_valid  output  1  dout holds unconsumed read data.
REQ-011 SHALL have port rd_ovf  output  1  one-cycle pulse: read command dropped.

Function
REQ-012 Opcodes SHALL be: 00 load wr_addr from payload[ADDR_W-1:0]; 01 write payload to mem[wr_addr]; 10 load rd_addr from payload[ADDR_W-1:0]; 11 read mem[rd_addr], payload ignored.
REQ-013 wr_addr and rd_addr SHALL be independent registers; loading one SHALL NOT change the other.
REQ-014 Commands SHALL act only when rx_valid=1; rx_valid=0 SHALL change no state except the tx handshake.
REQ-015 Output FSM SHALL have states IDLE (tx_valid=0) and HOLD (tx_valid=1).
REQ-016 Read in IDLE: dout SHALL update to mem[rd_addr] and tx_valid SHALL be 1 on the next edge (1-cycle latency); state -> HOLD.
REQ-017 In HOLD, dout and tx_valid SHALL stay stable until a cycle with tx_ready=1.
REQ-018 HOLD with tx_ready=1 and no read: state -> IDLE, tx_valid=0 next cycle, dout retains its last value.
REQ-019 HOLD with tx_ready=1 and a read the same cycle: read SHALL be accepted, dout reloads, state stays HOLD.
REQ-020 HOLD with tx_ready=0 and a read: read SHALL be dropped (no dout change, no rd_addr increment), rd_ovf=1 for one cycle.
REQ-021 Address loads and writes SHALL be accepted in any FSM state.
REQ-022 Write to address A then read of A on the next command SHALL return the newly written data.
REQ-023 Address values >= DEPTH: write SHALL be ignored, read SHALL return all-zeros with normal handshake.

Reset
REQ-024 While rst_n=0 at a rising clk: wr_addr=0, rd_addr=0, dout=0, tx_valid=0, rd_ovf=0, FSM=IDLE.
REQ-025 Reset SHALL override any simultaneous command or handshake, including mid-HOLD; pending read data is discarded.
REQ-026 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-027 Macro BURST_RAM_AUTOINC_EN defined: each accepted write SHALL increment wr_addr and each accepted read SHALL increment rd_addr, modulo DEPTH (DEPTH-1 wraps to 0).
REQ-028 Macro undefined: addresses SHALL change only on opcodes 00/10; dropped reads never increment.

Structure
REQ-029 Package burst_ram_pkg SHALL hold opcode constants OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_DATA and the FSM state type.
REQ-030 Storage SHALL be the sub-module burst_ram_mem (single-port, synchronous write, synchronous registered read, DEPTH x DATA_W); command decode, address registers and FSM stay in burst_ram.

Verification
REQ-031 Cmds 00/0x10, 01/0xA5, 10/0x10, 11 with tx_ready=1 -> tx_valid=1 one cycle after read, dout=0xA5.
REQ-032 Read then tx_ready=0 for 5 cycles plus second read -> dout stable, tx_valid=1, rd_ovf pulses once, rd_addr unchanged.
REQ-033 HOLD, tx_ready=1 and read of addr holding 0x3C same cycle -> tx_valid stays 1, dout=0x3C next cycle.
REQ-034 AUTOINC_EN: wr_addr=0xFE, write 0x11,0x22,0x33; rd_addr=0xFE, 3 reads -> 0x11,0x22,0x33 (wrap to 0x00).
REQ-035 rst_n=0 for one edge while in HOLD -> tx_valid=0, dout=0, addrs 0; earlier-written data still readable afterwards.
REQ-036 DEPTH=200: write 0x77 to addr 0xF0, read 0xF0 -> dout=0x00, memory unchanged.
